// File: rtl/wb_slave_mem.sv
// Wishbone classic slave memory with byte lanes and a configurable number of wait states.
// Define WB_SLV_ERR_EN to get an err termination for out-of-range addresses.
module wb_slave_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [ADDR_W-1:0]   wbs_adr_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  output logic [DATA_W-1:0]   wbs_dat_o,
  input  logic                wbs_we_i,
  input  logic [DATA_W/8-1:0] wbs_sel_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  output logic                wbs_ack_o,
  output logic                wbs_err_o
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_ack;
  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_hit;
  logic              w_req;
  logic              w_term_go;
  logic              w_wr;
  logic              w_unused;

  assign w_idx = wbs_adr_i[OFF_W +: IDX_W];
  assign w_req = wbs_cyc_i & wbs_stb_i;

  generate
    if (ADDR_W > OFF_W + IDX_W) begin : g_range
      assign w_in_range = ~|wbs_adr_i[ADDR_W-1:OFF_W+IDX_W];
    end else begin : g_no_range
      assign w_in_range = 1'b1;
    end
  endgenerate

`ifdef WB_SLV_ERR_EN
  logic r_err;
  assign w_hit     = w_in_range;
  assign wbs_err_o = r_err;
`else
  assign w_hit     = 1'b1;
  assign wbs_err_o = 1'b0;
`endif

  // Byte-offset bits (and, without the error option, the range check) are don't-cares.
  assign w_unused = &{1'b0, wbs_adr_i, w_in_range};

  // Terminal count is checked before the abort, so a cyc drop on the TERM entry edge still terminates.
  assign w_term_go = ((r_state == S_IDLE) && w_req && (WAIT_STATES == 0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_wr      = wb_rst_i & w_term_go & wbs_we_i & w_hit;

  always_ff @(posedge wb_clk_i) begin
    if (w_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbs_sel_i[i]) r_mem[w_idx][i*8 +: 8] <= wbs_dat_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
`ifdef WB_SLV_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef WB_SLV_ERR_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (WAIT_STATES == 0) begin
              r_state <= S_TERM;
            end else begin
              r_cnt   <= WS_LOAD;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_TERM;
          end else if (!wbs_cyc_i) begin
            r_cnt   <= 4'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_TERM:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_term_go) begin
        r_ack <= w_hit;
`ifdef WB_SLV_ERR_EN
        r_err <= ~w_hit;
`endif
        if (!wbs_we_i) r_dat <= w_hit ? r_mem[w_idx] : '0;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Randomised Wishbone bench for wb_slave_mem checked against an array-based memory model.
module tb_wb_slave_mem;

  localparam int WS    = 3;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        err;

  int n_checks;
  int n_fail;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_dat;

`ifdef WB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  wb_slave_mem #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_w),
    .wbs_dat_o(dat_r),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_ack_o(ack),
    .wbs_err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Raw bus cycle: returns latency in edges (0 = timed out) and the sampled termination.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd,
                     output logic a_o, output logic e_o, output int lat);
    @(negedge clk);
    adr = a; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    lat = 0; a_o = 1'b0; e_o = 1'b0; rd = 32'h0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        lat = n; a_o = ack; e_o = err; rd = dat_r;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // One checked transaction against the model; returns the sampled read data.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
    logic [31:0] word;
    int          idx;
    logic        hit;
    logic        a_o, e_o;
    int          lat;
    word = a >> 2;
    idx  = int'(word % DEPTH);
    hit  = (word < DEPTH) || !ERR_EN;
    bus(w, a, d, s, rd, a_o, e_o, lat);
    chk("latency", lat, WS + 1);
    chk("ack", {31'b0, a_o}, {31'b0, hit});
    chk("err", {31'b0, e_o}, {31'b0, !hit});
    if (w && hit) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    if (!w) exp_dat = hit ? model_mem[idx] : 32'h0;
    chk("dat_o", rd, exp_dat);
    @(posedge clk); #1;
    chk("term_pulse", {30'b0, ack, err}, 32'h0);
    $display("xact %s adr=%h dat=%h sel=%b rd=%h lat=%0d ack=%b err=%b",
             w ? "WR" : "RD", a, d, s, rd, lat, a_o, e_o);
  endtask

  logic [31:0] rd;
  logic [31:0] a;

  initial begin
    n_checks = 0; n_fail = 0; exp_dat = 32'h0;
    rst_n = 1'b0; adr = 0; dat_w = 0; we = 0; sel = 0; stb = 0; cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_dat", dat_r, 32'h0);

    // Give the pool of test words a defined value.
    for (int k = 0; k < 16; k++) xact(1'b1, k * 4, 32'h1000_0000 + k, 4'hF, rd);
    for (int k = 1020; k < 1024; k++) xact(1'b1, k * 4, 32'h2000_0000 + k, 4'hF, rd);

    xact(1'b1, 32'h3FC, 32'hDEADBEEF, 4'hF, rd);
    xact(1'b0, 32'h3FC, 32'h0, 4'hF, rd);
    chk("word_rb", rd, 32'hDEADBEEF);

    xact(1'b1, 32'h10, 32'h11223344, 4'hF, rd);
    xact(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, rd);
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd);
    chk("lanes", rd, 32'h11BB33DD);
    xact(1'b1, 32'h10, 32'h55667788, 4'b0000, rd);
    xact(1'b0, 32'h10, 32'h0, 4'hF, rd);
    chk("sel0", rd, 32'h11BB33DD);

    xact(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, rd);
    xact(1'b0, 32'h0, 32'h0, 4'hF, rd);
    chk("oor_word0", rd, ERR_EN ? 32'h1000_0000 : 32'hCAFEF00D);

    // Abort: drop cyc while waiting; no termination may follow.
    @(negedge clk);
    adr = 32'h8; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    repeat (2) @(posedge clk);
    #1; cyc = 1'b0; stb = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int n = 0; n < 8; n++) begin
        @(posedge clk); #1;
        if (ack || err) seen++;
      end
      chk("abort_noterm", seen, 0);
    end
    xact(1'b0, 32'h8, 32'h0, 4'hF, rd);

    // Reset while in WAIT with a write pending.
    xact(1'b0, 32'h20, 32'h0, 4'hF, rd);
    @(negedge clk);
    adr = 32'h20; dat_w = 32'hBAD0BAD0; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("midrst_ack", {31'b0, ack}, 32'h0);
    chk("midrst_err", {31'b0, err}, 32'h0);
    chk("midrst_dat", dat_r, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    exp_dat = 32'h0;
    xact(1'b0, 32'h20, 32'h0, 4'hF, rd);
    chk("midrst_mem", rd, 32'h1000_0008);

    for (int t = 0; t < 80; t++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      a = $urandom_range(0, 15) * 4;
      else if (kind < 8) a = $urandom_range(1020, 1023) * 4;
      else if (kind < 9) a = 32'h1000 + $urandom_range(0, 15) * 4;
      else               a = 32'h8000_0000 | ($urandom_range(0, 15) * 4);
      a = a | $urandom_range(0, 3);
      xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
